// File: rtl/count_wrap_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_wrap_tracker_pkg
//  Description : Shared constants for the mod-12 counter and its wrap
//                tracker: counter terminal value and width, direction
//                encodings and the event record width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package count_wrap_tracker_pkg;

    localparam int   CNT_MAX   = 11;
    localparam int   CNT_W     = 4;
    localparam int   LAP_W_DEF = 8;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Event record = {dir, lap}
    function automatic int evt_w(input int lap_w);
        return 1 + lap_w;
    endfunction

endpackage : count_wrap_tracker_pkg
`default_nettype wire

// File: rtl/count_wrap_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_wrap_tracker_if
//  Description : Valid/ready event stream carrying one {dir, lap} wrap record.
//                master = record producer (tracker), slave = consumer.
//  Ports       : evt_valid, evt_ready, evt_dir, evt_lap[LAP_W-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface count_wrap_tracker_if #(
    parameter int LAP_W = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic             evt_dir;
    logic [LAP_W-1:0] evt_lap;

    modport master (
        output evt_valid,
        output evt_dir,
        output evt_lap,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_dir,
        input  evt_lap,
        output evt_ready
    );
endinterface : count_wrap_tracker_if
`default_nettype wire

// File: rtl/count_wrap_tracker_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : count_wrap_tracker_evt_fifo
//  Description : Small synchronous FIFO for wrap records. Head data is read
//                straight from storage (no output register) and forced to 0
//                while empty. A push into a full FIFO is accepted only when a
//                pop happens in the same cycle; otherwise it is ignored.
//  Ports       : clk, reset (sync, active-high), push, pop, din, dout,
//                full, empty
//  Revision    : 1.0  initial release
// ============================================================================
module count_wrap_tracker_evt_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW-1:0]  c_PTR_ONE  = AW'(1);
    localparam logic [AW:0]    c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    c_CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == c_CNT_FULL);
    assign empty = (r_count == '0);
    assign w_rd  = pop & ~empty;
    // Full FIFO still takes a write when the head leaves in the same cycle
    assign w_wr  = push & (~full | w_rd);
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : count_wrap_tracker_evt_fifo
`default_nettype wire

// File: rtl/count_wrap_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : count_wrap_tracker
//  Description : Observes the mod-12 counter output every cycle, detects
//                wraps (MAX_VAL->0 up, 0->MAX_VAL down), keeps a signed lap
//                count and queues one {dir, lap} record per wrap for a
//                valid/ready consumer.
//  Ports       : clk, reset (sync, active-high)
//                cnt_in, cnt_load   observed counter value and its load strobe
//                evt (master)       evt_valid/evt_ready/evt_dir/evt_lap
//                ovf, ovf_clr       sticky record-dropped flag and its clear
//                rng_err            sticky out-of-range flag
//  Options     : `define CNT_RANGE_CHECK_EN enables rng_err and suppresses
//                wrap qualification across an out-of-range sample.
//  Revision    : 1.0  initial release
// ============================================================================
module count_wrap_tracker
    import count_wrap_tracker_pkg::*;
#(
    parameter int MAX_VAL    = CNT_MAX,
    parameter int LAP_W      = LAP_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [CNT_W-1:0] cnt_in,
    input  wire logic             cnt_load,
    count_wrap_tracker_if.master  evt,
    output logic                  ovf,
    input  wire logic             ovf_clr,
    output logic                  rng_err
);
    localparam int                EVT_W     = evt_w(LAP_W);
    localparam logic [CNT_W-1:0]  c_MAX     = CNT_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]  c_ZERO    = '0;
    localparam logic [LAP_W-1:0]  c_LAP_ONE = LAP_W'(1);

    logic [CNT_W-1:0] r_prev_q;
    logic             r_prev_vld;
    logic             r_load_q;
    logic [LAP_W-1:0] r_lap;
    logic             r_ovf;

    logic             w_qual;
    logic             w_up;
    logic             w_dn;
    logic             w_oor;
    logic [LAP_W-1:0] w_lap_next;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [EVT_W-1:0] w_din;
    logic [EVT_W-1:0] w_dout;

    // A sample that follows a load is the load value, not a count step
    always_comb begin
        w_qual     = r_prev_vld & ~r_load_q;
        w_up       = w_qual & (r_prev_q == c_MAX)  & (cnt_in == c_ZERO);
        w_dn       = w_qual & (r_prev_q == c_ZERO) & (cnt_in == c_MAX);
        w_lap_next = r_lap;
        if (w_up) begin
            w_lap_next = r_lap + c_LAP_ONE;
        end else if (w_dn) begin
            w_lap_next = r_lap - c_LAP_ONE;
        end
    end

    assign w_push = w_up | w_dn;
    assign w_pop  = ~w_empty & evt.evt_ready;
    assign w_drop = w_push & w_full & ~w_pop;
    assign w_din  = {(w_dn ? DIR_DN : DIR_UP), w_lap_next};

`ifdef CNT_RANGE_CHECK_EN
    logic r_rng_err;

    assign w_oor = (cnt_in > c_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rng_err <= 1'b0;
        end else if (w_oor) begin
            r_rng_err <= 1'b1;
        end
    end

    assign rng_err = r_rng_err;
`else
    assign w_oor   = 1'b0;
    assign rng_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_q   <= '0;
            r_prev_vld <= 1'b0;
            r_load_q   <= 1'b0;
            r_lap      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_prev_q   <= cnt_in;
            // An out-of-range sample cannot anchor the next wrap check
            r_prev_vld <= ~w_oor;
            r_load_q   <= cnt_load;
            // Lap tracks every wrap even when its record is dropped
            r_lap      <= w_lap_next;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign ovf = r_ovf;

    count_wrap_tracker_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign evt.evt_valid = ~w_empty;
    assign evt.evt_dir   = w_dout[EVT_W-1];
    assign evt.evt_lap   = w_dout[LAP_W-1:0];

endmodule : count_wrap_tracker
`default_nettype wire

// File: tb/tb_count_wrap_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_wrap_tracker
//  Description : Self-checking bench for count_wrap_tracker. A reference
//                model of sampler, lap counter, ovf flag and a 4-entry record
//                queue predicts each record on push; records are compared
//                when the DUT hands them over on evt_valid & evt_ready.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_wrap_tracker;

    typedef struct {
        logic       dir;
        logic [7:0] lap;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cnt_in;
    logic       cnt_load;
    logic       ovf_clr;
    logic       ovf;
    logic       rng_err;

    count_wrap_tracker_if #(.LAP_W(8)) evt_if ();

    count_wrap_tracker #(
        .MAX_VAL    (11),
        .LAP_W      (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cnt_in   (cnt_in),
        .cnt_load (cnt_load),
        .evt      (evt_if),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .rng_err  (rng_err)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    rec_t exp_q[$];

    // reference model state
    logic [3:0] m_prev;
    logic       m_pvld;
    logic       m_ldq;
    logic [7:0] m_lap;
    logic       m_ovf;
    logic       m_rng;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_prev = 4'd0;
        m_pvld = 1'b0;
        m_ldq  = 1'b0;
        m_lap  = 8'd0;
        m_ovf  = 1'b0;
        m_rng  = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        cnt_in   = 4'd0;
        cnt_load = 1'b0;
        evt_if.evt_ready = 1'b0;
        ovf_clr  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        chk("rst_dir",   {31'd0, evt_if.evt_dir},   32'd0);
        chk("rst_lap",   {24'd0, evt_if.evt_lap},   32'd0);
        chk("rst_ovf",   {31'd0, ovf},              32'd0);
        chk("rst_rng",   {31'd0, rng_err},          32'd0);
    endtask

    // One clock: drive, check registered outputs mid-cycle, advance the model
    task automatic cyc(input logic [3:0] c, input logic ld, input logic rdy, input logic clr);
        int   size_b;
        logic pop, qual, up, dn, oor, drop;
        rec_t r;
        cnt_in   = c;
        cnt_load = ld;
        evt_if.evt_ready = rdy;
        ovf_clr  = clr;
        @(negedge clk);
        size_b = exp_q.size();
        chk("valid",   {31'd0, evt_if.evt_valid}, {31'd0, size_b != 0});
        chk("ovf",     {31'd0, ovf},              {31'd0, m_ovf});
        chk("rng_err", {31'd0, rng_err},          {31'd0, m_rng});
        pop = rdy && (size_b != 0);
        if (pop) begin
            r = exp_q.pop_front();
            chk("evt_dir", {31'd0, evt_if.evt_dir}, {31'd0, r.dir});
            chk("evt_lap", {24'd0, evt_if.evt_lap}, {24'd0, r.lap});
        end
        oor = 1'b0;
`ifdef CNT_RANGE_CHECK_EN
        oor = (c > 4'd11);
`endif
        qual = m_pvld && !m_ldq;
        up   = qual && (m_prev == 4'd11) && (c == 4'd0);
        dn   = qual && (m_prev == 4'd0)  && (c == 4'd11);
        if (up) m_lap = m_lap + 8'd1;
        if (dn) m_lap = m_lap - 8'd1;
        drop = (up || dn) && (size_b == 4) && !pop;
        if ((up || dn) && !drop) begin
            r.dir = dn;
            r.lap = m_lap;
            exp_q.push_back(r);
        end
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (oor) m_rng = 1'b1;
        m_prev = c;
        m_pvld = !oor;
        m_ldq  = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        cnt_in   = 4'd0;
        cnt_load = 1'b0;
        ovf_clr  = 1'b0;
        evt_if.evt_ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // up wrap from reset: {up, lap 1}
        cyc(4'd10, 0, 0, 0);
        cyc(4'd11, 0, 0, 0);
        cyc(4'd0,  0, 0, 0);
        chk("t1_valid", {31'd0, evt_if.evt_valid}, 32'd1);
        chk("t1_dir",   {31'd0, evt_if.evt_dir},   32'd0);
        chk("t1_lap",   {24'd0, evt_if.evt_lap},   32'd1);
        cyc(4'd1, 0, 1, 0);

        // down wrap from reset: {down, lap 8'hFF}
        do_reset();
        cyc(4'd1,  0, 0, 0);
        cyc(4'd0,  0, 0, 0);
        cyc(4'd11, 0, 0, 0);
        cyc(4'd10, 0, 0, 0);
        chk("t2_dir", {31'd0, evt_if.evt_dir}, 32'd1);
        chk("t2_lap", {24'd0, evt_if.evt_lap}, 32'hFF);
        cyc(4'd10, 0, 1, 0);

        // load into 0 right after 11: no record
        cyc(4'd10, 0, 1, 0);
        cyc(4'd11, 1, 1, 0);
        cyc(4'd0,  0, 1, 0);
        cyc(4'd1,  0, 1, 0);

        // five up wraps with no consumer: 4 kept, 1 dropped, ovf set
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(4'd11, 0, 0, 0);
            cyc(4'd0,  0, 0, 0);
            cyc(4'd5,  0, 0, 0);
        end
        chk("t4_ovf", {31'd0, ovf}, 32'd1);
        cyc(4'd5, 0, 0, 1);
        cyc(4'd5, 0, 0, 0);
        chk("t4_ovf_clr", {31'd0, ovf}, 32'd0);
        // full FIFO, wrap coincides with a pop: both accepted, lap continues at 6
        cyc(4'd11, 0, 0, 0);
        cyc(4'd0,  0, 1, 0);
        cyc(4'd5,  0, 0, 0);
        chk("t5_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 5; i++) cyc(4'd5, 0, 1, 0);

        // reset with 3 records queued, then 11,0 right after reset
        for (int i = 0; i < 3; i++) begin
            cyc(4'd11, 0, 0, 0);
            cyc(4'd0,  0, 0, 0);
            cyc(4'd5,  0, 0, 0);
        end
        do_reset();
        cyc(4'd11, 0, 0, 0);
        cyc(4'd0,  0, 0, 0);
        cyc(4'd0,  0, 0, 0);
        // out-of-range sample between 11 and 0
        cyc(4'd13, 0, 0, 0);
        cyc(4'd11, 0, 0, 0);
        cyc(4'd13, 0, 0, 0);
        cyc(4'd0,  0, 0, 0);
        cyc(4'd0,  0, 1, 0);
        cyc(4'd0,  0, 1, 0);

        // random stretch biased towards the wrap values
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int   v;
            logic [3:0] c;
            v = $urandom_range(0, 3);
            if (v == 0)      c = 4'd0;
            else if (v == 1) c = 4'd11;
            else             c = 4'($urandom_range(0, 15));
            cyc(c, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 6; i++) cyc(4'd5, 0, 1, 0);
        chk("drain_empty", {31'd0, evt_if.evt_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_count_wrap_tracker
`default_nettype wire
